// File: rtl/student_mux8way_rr_pkg.sv
// Shared widths and helpers for the 8-way round-robin gathering mux.
package student_mux8way_rr_pkg;

  localparam int WORD_W = 16;
  localparam int SEL8_W = 3;
  localparam int N_CH   = 8;

  typedef logic [SEL8_W-1:0] sel8_t;

  // Pointer advance after a grant; 7 wraps naturally to 0 in 3 bits.
  function automatic sel8_t next_ptr(input sel8_t gidx);
    return sel8_t'(gidx + sel8_t'(1));
  endfunction

endpackage

// File: rtl/student_dmux8way.sv
// 1-to-8 demux: drives the selected output with in, all others low.
module student_dmux8way
  import student_mux8way_rr_pkg::*;
(
  input  logic            in,
  input  sel8_t           sel,
  output logic [N_CH-1:0] out
);

  // One-hot decode of sel, gated by in.
  always_comb begin
    out      = '0;
    out[sel] = in;
  end

endmodule

// File: rtl/student_rr_pick8.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module student_rr_pick8
  import student_mux8way_rr_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  sel8_t           ptr,
  output sel8_t           gidx,
  output logic            any
);

  // Scan ptr+7 down to ptr so the lowest rotated offset overwrites last and wins.
  always_comb begin
    sel8_t idx;
    gidx = '0;
    any  = 1'b0;
    idx  = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = sel8_t'(ptr + sel8_t'(k));
      if (req[idx]) begin
        gidx = idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/student_mux8way_rr.sv
// 8-channel valid/ready gathering mux with a registered output stage.
// Each output word carries its source channel index in out_sel.
module student_mux8way_rr
  import student_mux8way_rr_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter bit RR_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output sel8_t                 out_sel,
  input  logic                  out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  sel8_t            out_sel_q,   out_sel_d;
  sel8_t            ptr_q,       ptr_d;

  logic  load_en;
  logic  any;
  sel8_t gidx;
  logic  accept;

  student_rr_pick8 u_pick (
    .req  (in_valid),
    .ptr  (ptr_q),
    .gidx (gidx),
    .any  (any)
  );

  // rst_n gates the handshake so nothing is accepted while reset is held.
  assign load_en = !out_valid_q || out_ready;
  assign accept  = load_en && any && rst_n;

  student_dmux8way u_dmux (
    .in  (accept),
    .sel (gidx),
    .out (in_ready)
  );

  // Next-state for the output register and round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      if (any) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data[int'(gidx)*WIDTH +: WIDTH];
        out_sel_d   = gidx;
        ptr_d       = RR_EN ? next_ptr(gidx) : sel8_t'(0);
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Output stage and pointer registers; async clear drops any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_student_mux8way_rr.sv
module tb_student_mux8way_rr;

  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic [7:0]     in_valid;
  logic [8*W-1:0] in_data;
  logic [7:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [2:0]     out_sel;
  logic           out_ready;

  int total;
  int bad;

  student_mux8way_rr #(.WIDTH(W), .RR_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake invariants checked at every rising edge.
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      total++;
      if (!$onehot0(in_ready) || ((in_ready & ~in_valid) != 8'h00)) begin
        bad++;
        $display("FAIL handshake_invariant in_ready=%h in_valid=%h", in_ready, in_valid);
      end
    end
  end

  task automatic set_default_data();
    for (int i = 0; i < 8; i++) in_data[i*W +: W] = 16'h1000 + 16'(i);
  endtask

  task automatic chk_out(input string name, input logic v, input logic [W-1:0] d, input logic [2:0] s);
    total++;
    if (out_valid !== v || out_data !== d || out_sel !== s) begin
      bad++;
      $display("FAIL %s got v=%b d=%h s=%0d want v=%b d=%h s=%0d",
               name, out_valid, out_data, out_sel, v, d, s);
    end
  endtask

  task automatic chk_rdy(input string name, input logic [7:0] exp);
    total++;
    if (in_ready !== exp) begin
      bad++;
      $display("FAIL %s in_ready got %h want %h", name, in_ready, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 8'hFF; out_ready = 1'b1;
    set_default_data();
    @(negedge clk); #1;
    chk_rdy("reset_in_ready", 8'h00);
    chk_out("reset_out", 1'b0, 16'h0000, 3'd0);
    @(negedge clk);
    rst_n = 1'b1; #1;
    chk_rdy("reset_first_ready", 8'h01);
    @(posedge clk); #1;
    chk_out("reset_first_grant", 1'b1, 16'h1000, 3'd0);
  endtask

  task automatic test_single();
    @(negedge clk);
    in_valid = 8'h20; in_data[5*W +: W] = 16'hBEEF; out_ready = 1'b1; #1;
    chk_rdy("single_ready", 8'h20);
    @(posedge clk); #1;
    chk_out("single_out", 1'b1, 16'hBEEF, 3'd5);
    @(negedge clk);
    in_valid = 8'h00; #1;
    chk_rdy("idle_ready", 8'h00);
    @(posedge clk); #1;
    chk_out("idle_hold", 1'b0, 16'hBEEF, 3'd5);
    set_default_data();
  endtask

  task automatic test_round_robin();
    do_reset();
    in_valid = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk_out($sformatf("rr_%0d", i), 1'b1, 16'h1000 + 16'(i % 8), 3'(i % 8));
    end
  endtask

  task automatic test_backpressure();
    // Output holds ch1, ptr=2.
    @(negedge clk);
    out_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk_rdy($sformatf("bp_ready_%0d", i), 8'h00);
      @(posedge clk); #1;
      chk_out($sformatf("bp_hold_%0d", i), 1'b1, 16'h1001, 3'd1);
      @(negedge clk); #1;
    end
    out_ready = 1'b1; #1;
    chk_rdy("bp_refill_ready", 8'h04);
    @(posedge clk); #1;
    chk_out("bp_refill", 1'b1, 16'h1002, 3'd2);
  endtask

  task automatic test_wrap_skip();
    // ptr=3: grant ch6 moves ptr to 7.
    @(negedge clk);
    in_valid = 8'h40;
    @(posedge clk); #1;
    chk_out("wrap_setup", 1'b1, 16'h1006, 3'd6);
    @(negedge clk);
    in_valid = 8'h12; #1;
    chk_rdy("wrap_ready", 8'h02);
    @(posedge clk); #1;
    chk_out("wrap_grant", 1'b1, 16'h1001, 3'd1);
    @(negedge clk); #1;
    chk_rdy("skip_ready", 8'h10);
    @(posedge clk); #1;
    chk_out("skip_grant", 1'b1, 16'h1004, 3'd4);
  endtask

  task automatic test_midstream_reset();
    // ptr=5, out_valid=1.
    @(negedge clk);
    in_valid = 8'h81;
    #2 rst_n = 1'b0;
    #1;
    chk_out("mid_reset_out", 1'b0, 16'h0000, 3'd0);
    chk_rdy("mid_reset_ready", 8'h00);
    @(negedge clk);
    rst_n = 1'b1; #1;
    chk_rdy("post_reset_ready", 8'h01);
    @(posedge clk); #1;
    chk_out("post_reset_grant", 1'b1, 16'h1000, 3'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    in_valid = 8'h00;
    in_data = '0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_midstream_reset();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
